md_sequencer: RTL and testbench
===============================

# md_sequencer

Iterative multiply/divide unit with its own sequencing FSM, serving the pipeline's HI/LO-based MULT/MULTU/DIV/DIVU and MTHI/MTLO instructions. It accepts a one-cycle start from the execute stage and runs a one-bit-per-cycle shift-add multiply or restoring divide on operand magnitudes. A final sign-fix cycle follows, then HI/LO is committed. While it runs, it drives the run flag that the pipeline uses to stall HI/LO accesses and to gate the HI/LO-disable path.

## Interface
- WIDTH, 32, operand and HI/LO width; the counter is log2(WIDTH) bits.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  pulse from execute stage (mdstartE); sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- srca  in  WIDTH  rs operand (multiplicand / dividend).
- srcb  in  WIDTH  rt operand (multiplier / divisor).
- cancel  in  1  abort in-flight operation (exception/interrupt flush).
- hilo_wr  in  1  MTHI/MTLO write strobe.
- hilo_sel  in  1  0 = LO, 1 = HI for hilo_wr.
- wdata  in  WIDTH  MTHI/MTLO data.
- run  out  1  operation in flight (mdrunE); high in BUSY and FIX.
- done  out  1  one-cycle pulse, registered, in the first IDLE cycle after a commit.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States are IDLE, BUSY and FIX. run is 1 when the state is BUSY or FIX.
- IDLE with start=1 and cancel=0:
  - Latch |srca| and |srcb|. For signed ops, use two's-complement magnitude; 0x80000000 maps to 0x80000000 unsigned. For unsigned ops, use the raw value.
  - Latch neg_q = sign(a) XOR sign(b), for signed ops only.
  - Latch neg_r = sign(a), for signed DIV only.
  - Load counter = WIDTH-1 and go to BUSY.
- Multiply in BUSY, 2·WIDTH accumulator:
  - If the multiplier LSB is 1, add the multiplicand into the upper half.
  - Shift the accumulator right 1 with carry-in.
  - Shift the multiplier right 1.
- Divide in BUSY, restoring:
  - Form {rem, quo} and shift left 1.
  - Compute trial = rem − divisor, WIDTH+1 bits.
  - If trial is non-negative, rem = trial and quo[0] = 1; else quo[0] = 0.
- BUSY: when counter = 0, go to FIX; else decrement the counter.
- FIX, one cycle, sign correction:
  - Multiply: negate the 64-bit product if neg_q.
  - Divide: negate the quotient if neg_q; negate the remainder if neg_r.
  - Commit to {hi, lo}: multiply gives hi = product[63:32], lo = product[31:0]; divide gives hi = remainder, lo = quotient.
  - Go to IDLE. done = 1 on the next cycle.
- Divide by zero produces no exception:
  - DIVU: lo = 0xFFFFFFFF, hi = srca.
  - DIV: lo = 0xFFFFFFFF if srca ≥ 0, else 0x00000001; hi = srca.
- DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- hilo_wr in IDLE: write wdata to the register selected by hilo_sel at the edge. hilo_wr while run=1 is ignored, because the pipeline stalls the instruction.
- Precedence in IDLE: cancel over start over hilo_wr.
  - start and hilo_wr in the same cycle: start proceeds and the write is dropped.
  - cancel and start in the same cycle: nothing starts.
- cancel in BUSY or FIX: go to IDLE at the edge with hi/lo unchanged and no done pulse.
- start while run=1: ignored.

## Timing
- Reset values: state IDLE, run 0, done 0, hi 0, lo 0, counter 0.
- start sampled at edge E0.
- run is high from the cycle after E0 for WIDTH+1 cycles (33 for WIDTH=32): 32 cycles in BUSY, 1 in FIX.
- hi/lo show the new result in the cycle after the FIX edge. That is the same cycle done = 1 and run = 0.
- Total latency from start to result visible is WIDTH+2 cycles.
- A new start is accepted in the same cycle done is high.
- hilo_wr takes effect at the next edge; a read in the following cycle sees the new value.
- reset asserted in any state wins over everything: next cycle is IDLE with all outputs 0.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → run high exactly 33 cycles, then hi = 0xFFFFFFFE, lo = 0x00000001, done pulse 1 cycle.
- MULT −3 × 5 (0xFFFFFFFD, 0x00000005) → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
- DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 7 / 0 → lo = 0xFFFFFFFF, hi = 7. DIV 0x80000000 / −1 → lo = 0x80000000, hi = 0.
- MULTU 2 × 3, cancel at run cycle 10 → run = 0 next cycle, hi/lo keep prior values, no done. start pulsed mid-BUSY → ignored, result unchanged.
- hilo_wr with hilo_sel = 1, wdata = 0x1234 in IDLE → hi = 0x1234 next cycle. The same write during run → ignored. hilo_wr together with start → write dropped.
- reset asserted at BUSY cycle 5 → next cycle run = 0, done = 0, hi = lo = 0. A subsequent DIVU 100 / 7 → lo = 14, hi = 2.

Source files
------------

// File: rtl/md_sequencer_if.sv
// Pipeline <-> multiply/divide sequencer bundle.
//
// Handshake: start is a single-cycle request qualified by run. A start is
// accepted at the rising edge only when run=0 and cancel=0; the operands and
// op are sampled at that same edge. There is no back-pressure beyond run: a
// start (or hilo_wr) seen while run=1 is simply dropped, because the pipeline
// stalls those instructions. Completion is signalled by a one-cycle done
// pulse in the first cycle hi/lo hold the new result.
interface md_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             cancel;
  logic             hilo_wr;
  logic             hilo_sel;
  logic [WIDTH-1:0] wdata;
  logic             run;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Execute-stage side.
  modport master (
    output start, op, srca, srcb, cancel, hilo_wr, hilo_sel, wdata,
    input  run, done, hi, lo
  );

  // Sequencer side.
  modport slave (
    input  start, op, srca, srcb, cancel, hilo_wr, hilo_sel, wdata,
    output run, done, hi, lo
  );
endinterface

// File: rtl/md_sequencer.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle on operand
// magnitudes (shift-add multiply, restoring divide), then a sign-fix cycle
// that commits the result to HI/LO.
module md_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  md_sequencer_if.slave      md,
  output logic [1:0]         state_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q_q, neg_q_d;     // negate product / quotient
  logic             neg_r_q, neg_r_d;     // negate remainder
  logic [WIDTH-1:0] dvs_q, dvs_d;         // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // product high half / remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // multiplier->product low / quotient
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             accept;
  logic             commit;
  logic             wr_hilo;
  logic             signed_op;

  // Magnitude of a possibly signed operand; the most negative value maps to
  // itself, which is exactly its unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                           input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // One step of each algorithm, computed from the current accumulator.
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic               trial_ge;
  logic [WIDTH-1:0]   trial_rem;
  logic [2*WIDTH-1:0] product_fix;

  assign signed_op   = ~md.op[0];
  assign add_sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, dvs_q} : '0);
  assign shifted     = {acc_hi_q, acc_lo_q[WIDTH-1]};
  // trial = shifted - divisor is non-negative exactly when shifted >= divisor;
  // the remainder always stays below the divisor, so it fits in WIDTH bits.
  assign trial_ge    = (shifted >= {1'b0, dvs_q});
  assign trial_rem   = shifted[WIDTH-1:0] - dvs_q;
  assign product_fix = neg_q_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

  // Sequencing: who wins this cycle and where the FSM goes next.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    wr_hilo = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!md.cancel && md.start) begin
          accept  = 1'b1;
          state_d = S_BUSY;
        end else if (!md.cancel && md.hilo_wr) begin
          wr_hilo = 1'b1;
        end
      end
      S_BUSY: begin
        if (md.cancel)          state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_FIX;
      end
      S_FIX: begin
        commit  = ~md.cancel;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next state: operand latch, iteration step, sign fix and commit.
  always_comb begin
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dvs_d    = dvs_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = commit;

    if (accept) begin
      // Multiply is commutative, so srca always seeds the low accumulator
      // (multiplier or dividend) and srcb the operand register.
      dvs_d    = mag(md.srcb, signed_op);
      acc_lo_d = mag(md.srca, signed_op);
      acc_hi_d = '0;
      is_div_d = md.op[1];
      neg_q_d  = signed_op & (md.srca[WIDTH-1] ^ md.srcb[WIDTH-1]);
      neg_r_d  = signed_op & md.op[1] & md.srca[WIDTH-1];
      cnt_d    = CW'(WIDTH - 1);
    end else if (state_q == S_BUSY) begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      if (is_div_q) begin
        acc_hi_d = trial_ge ? trial_rem : shifted[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], trial_ge};
      end else begin
        acc_hi_d = add_sum[WIDTH:1];
        acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
      end
    end

    if (commit) begin
      if (is_div_q) begin
        hi_d = neg_r_q ? -acc_hi_q : acc_hi_q;
        lo_d = neg_q_q ? -acc_lo_q : acc_lo_q;
      end else begin
        hi_d = product_fix[2*WIDTH-1:WIDTH];
        lo_d = product_fix[WIDTH-1:0];
      end
    end

    if (wr_hilo) begin
      if (md.hilo_sel) hi_d = md.wdata;
      else             lo_d = md.wdata;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dvs_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dvs_q    <= dvs_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign md.run  = (state_q == S_BUSY) || (state_q == S_FIX);
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed corner cases plus random operations,
// checked against an arithmetic model of HI/LO.
module tb_md_sequencer;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  md_sequencer_if #(.WIDTH(W)) bus();
  md_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .md      (bus),
    .state_o (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   ref_hi, ref_lo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural result {hi, lo} of one operation.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(sa * sb); return p; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; return p; end
      2'b10: begin
        if (b == 0) return {a, (a[W-1] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Driver: one operation. mid_kind 1 = stray start, 2 = hilo_wr, at run
  // cycle mid_at. with_wr raises hilo_wr alongside start. chain leaves the
  // bench in the done cycle so the next call starts there.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int mid_kind, input int mid_at,
                        input bit with_wr, input bit chain);
    int run_cnt;
    logic [63:0] exp;
    logic [W-1:0] hi_before;
    exp_q.push_back(model(op, a, b));
    hi_before = ref_hi;
    bus.op = op; bus.srca = a; bus.srcb = b; bus.start = 1'b1;
    if (with_wr) begin
      bus.hilo_wr = 1'b1; bus.hilo_sel = 1'b0; bus.wdata = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    bus.start = 1'b0; bus.hilo_wr = 1'b0;
    if (with_wr) check({tag, "_wr_dropped"}, bus.lo, ref_lo);
    run_cnt = 0;
    while (bus.run === 1'b1 && run_cnt < 200) begin
      run_cnt++;
      if (run_cnt == mid_at && mid_kind == 1) begin
        bus.start = 1'b1; bus.op = 2'($urandom_range(0, 3));
        bus.srca = $urandom; bus.srcb = $urandom;
      end
      if (run_cnt == mid_at && mid_kind == 2) begin
        bus.hilo_wr = 1'b1; bus.hilo_sel = 1'b1; bus.wdata = 32'h1234;
      end
      @(negedge clk);
      bus.start = 1'b0; bus.hilo_wr = 1'b0;
      if (run_cnt == mid_at && mid_kind == 2)
        check({tag, "_wr_in_run"}, bus.hi, hi_before);
    end
    check({tag, "_run_cycles"}, run_cnt, W + 1);
    check({tag, "_done"}, bus.done, 1);
    exp = exp_q.pop_front();
    check({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
    ref_hi = exp[63:32];
    ref_lo = exp[31:0];
    if (!chain) begin
      @(negedge clk);
      check({tag, "_done_clear"}, bus.done, 0);
    end
  endtask

  // Driver: start an op then cancel at run cycle 'at' (0 = same cycle as start).
  task automatic cancel_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int at);
    int run_cnt;
    bit saw_done;
    bus.op = 2'b01; bus.srca = a; bus.srcb = b; bus.start = 1'b1;
    bus.cancel = (at == 0);
    @(negedge clk);
    bus.start = 1'b0;
    run_cnt = 0;
    while (bus.run === 1'b1 && run_cnt < at) begin
      run_cnt++;
      if (run_cnt == at) bus.cancel = 1'b1;
      @(negedge clk);
    end
    bus.cancel = 1'b0;
    check({tag, "_run"}, bus.run, 0);
    check({tag, "_hilo"}, {bus.hi, bus.lo}, {ref_hi, ref_lo});
    saw_done = bus.done;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | bus.done;
    end
    check({tag, "_no_done"}, saw_done, 0);
  endtask

  task automatic write_hilo(input logic sel, input logic [W-1:0] data);
    bus.hilo_wr = 1'b1; bus.hilo_sel = sel; bus.wdata = data;
    @(negedge clk);
    bus.hilo_wr = 1'b0;
    if (sel) ref_hi = data; else ref_lo = data;
    check("hilo_wr", {bus.hi, bus.lo}, {ref_hi, ref_lo});
  endtask

  task automatic reset_mid(input int at);
    int run_cnt;
    bus.op = 2'b01; bus.srca = 32'h55; bus.srcb = 32'h77; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    run_cnt = 0;
    while (bus.run === 1'b1 && run_cnt < at) begin
      run_cnt++;
      if (run_cnt == at) reset = 1'b1;
      @(negedge clk);
    end
    reset = 1'b1;
    ref_hi = '0; ref_lo = '0;
    check("rst_mid_run", bus.run, 0);
    check("rst_mid_done", bus.done, 0);
    check("rst_mid_hilo", {bus.hi, bus.lo}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      3:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 0; bus.op = 0; bus.srca = 0; bus.srcb = 0; bus.cancel = 0;
    bus.hilo_wr = 0; bus.hilo_sel = 0; bus.wdata = 0;
    reset = 1'b1;
    ref_hi = '0; ref_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_run", bus.run, 0);
    check("reset_done", bus.done, 0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'h0);

    run_op("multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
    run_op("mult_neg",    2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 0, 0, 0, 0);
    run_op("mult_min",    2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0);
    run_op("div_neg",     2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 0, 0);
    run_op("divu_zero",   2'b11, 32'h0000_0007, 32'h0000_0000, 0, 0, 0, 0);
    run_op("div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
    run_op("div_zero_ng", 2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 0, 0, 0, 0);
    run_op("div_zero_ps", 2'b10, 32'h0000_0123, 32'h0000_0000, 0, 0, 0, 0);

    cancel_op("cancel_busy", 32'h2, 32'h3, 10);
    cancel_op("cancel_fix",  32'h2, 32'h3, W + 1);
    cancel_op("cancel_start", 32'h2, 32'h3, 0);

    run_op("stray_start", 2'b01, 32'h2, 32'h3, 1, 5, 0, 0);
    write_hilo(1'b1, 32'h1234);
    write_hilo(1'b0, 32'hCAFE);
    run_op("wr_in_run",   2'b11, 32'd100, 32'd7, 2, 8, 0, 0);
    run_op("wr_w_start",  2'b01, 32'd9, 32'd9, 0, 0, 1, 0);
    run_op("chain_a",     2'b00, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0, 0, 0, 1);
    run_op("chain_b",     2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 0, 0, 0, 0);

    reset_mid(5);
    run_op("divu_rst",    2'b11, 32'd100, 32'd7, 0, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      run_op("rand", 2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 0, 0, 0,
             1'($urandom_range(0, 1)));
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
